// File: rtl/pmu_pkg.sv
// Shared types and header layout for the PMU frame controller.
// The 64-bit header arrives LSB first: frame_count, last_len, chain_sel, reserved.
package pmu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CRC,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } pmu_state_e;

   localparam int unsigned HDR_W   = 64;

   localparam int unsigned FC_LSB  = 0;
   localparam int unsigned FC_W    = 32;
   localparam int unsigned LL_LSB  = 32;
   localparam int unsigned LL_W    = 16;
   localparam int unsigned CS_LSB  = 48;
   localparam int unsigned CS_W    = 8;
   localparam int unsigned RSV_LSB = 56;
   localparam int unsigned RSV_W   = 8;

   // Number of clocked bits in the last frame: 0 or anything above the frame size means a full frame.
   function automatic logic [LL_W:0] eff_len(input logic [LL_W-1:0] last_len,
                                             input int unsigned     frame_w);
      logic [LL_W:0] fw;
      fw = frame_w[LL_W:0];
      if (last_len == '0 || {1'b0, last_len} > fw) begin
         return fw;
      end
      return {1'b0, last_len};
   endfunction

endpackage

// File: rtl/pmu_crc.sv
// MSB-feedback CRC LFSR; a frame followed by its own CRC leaves a zero remainder.
module pmu_crc
   import pmu_pkg::*;
#(
   parameter int unsigned          CRC_W    = 8,
   parameter logic [CRC_W-1:0]     CRC_POLY = 8'h2F
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clear_i,
   input  logic             bit_i,
   output logic [CRC_W-1:0] rem_o
);

   logic [CRC_W-1:0] rem_q;
   logic             fb;

   assign fb    = rem_q[CRC_W-1] ^ bit_i;
   assign rem_o = rem_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q <= '0;
      end else if (clear_i) begin
         rem_q <= '0;
      end else if (en_i) begin
         rem_q <= {rem_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
      end
   end

endmodule

// File: rtl/pmu_frame_ctrl.sv
// Frame controller streaming a serial bitstream into one of N_CHAINS configuration chains.
// Define PMU_CRC_EN to add a per-frame CRC phase (CRC + CHECK states, pmu_crc instance).
module pmu_frame_ctrl
   import pmu_pkg::*;
#(
   parameter int unsigned      N_CHAINS = 4,
   parameter int unsigned      FRAME_W  = 64,
   parameter int unsigned      CRC_W    = 8,
   parameter logic [CRC_W-1:0] CRC_POLY = 8'h2F
) (
   input  logic                tck_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                data_i,
   input  logic [N_CHAINS-1:0] data_ccff_i,
   output logic                data_o,
   output logic [N_CHAINS-1:0] progclk_o,
   output logic                data_ccff_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned BIT_W = $clog2(FRAME_W);
   localparam int unsigned AUX_W = $clog2(HDR_W);

   pmu_state_e        state_q, state_d;
   logic [HDR_W-1:0]  hdr_q, hdr_next;
   logic [AUX_W-1:0]  aux_cnt_q;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic [FC_W-1:0]   frames_q;
   logic              done_q, err_q;
   logic              clk_en_q, clk_en_d;
   logic [CRC_W-1:0]  crc_rem;

   logic              hdr_last, hdr_bad, bit_last, crc_last, last_frame, bit_in_len;
   logic [CS_W-1:0]   chain_sel;
   logic [LL_W:0]     len_lim;

   assign hdr_next   = {data_i, hdr_q[HDR_W-1:1]};
   assign hdr_last   = (aux_cnt_q == AUX_W'(HDR_W - 1));
   assign hdr_bad    = (hdr_next[FC_LSB +: FC_W] == '0) ||
                       (32'(hdr_next[CS_LSB +: CS_W]) >= N_CHAINS);
   assign bit_last   = (bit_cnt_q == BIT_W'(FRAME_W - 1));
   assign crc_last   = (aux_cnt_q == AUX_W'(CRC_W - 1));
   assign last_frame = (frames_q == FC_W'(1));
   assign chain_sel  = hdr_q[CS_LSB +: CS_W];
   assign len_lim    = eff_len(hdr_q[LL_LSB +: LL_W], FRAME_W);
   assign bit_in_len = ({{(LL_W + 1 - BIT_W){1'b0}}, bit_cnt_q} < len_lim);

`ifdef PMU_CRC_EN
   logic crc_en, crc_clr;

   assign crc_en  = en_i && (state_q == ST_DATA || state_q == ST_CRC);
   assign crc_clr = !en_i || state_q == ST_IDLE || state_q == ST_HDR || state_q == ST_CHECK;

   pmu_crc #(
      .CRC_W    (CRC_W),
      .CRC_POLY (CRC_POLY)
   ) u_crc (
      .clk_i   (tck_i),
      .rst_i   (rst_i),
      .en_i    (crc_en),
      .clear_i (crc_clr),
      .bit_i   (data_i),
      .rem_o   (crc_rem)
   );
`else
   // Without the LFSR there is never a remainder; the polynomial only keeps its parameter referenced.
   assign crc_rem = CRC_POLY & '0;
`endif

   always_ff @(posedge tck_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_HDR;
            ST_HDR: begin
               if (hdr_last) begin
                  state_d = hdr_bad ? ST_ERROR : ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_last) begin
`ifdef PMU_CRC_EN
                  state_d = ST_CRC;
`else
                  if (last_frame) begin
                     state_d = ST_DONE;
                  end
`endif
               end
            end
            ST_CRC: begin
               if (crc_last) begin
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (crc_rem != '0) begin
                  state_d = ST_ERROR;
               end else if (last_frame) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Session datapath; done/err survive en_i dropping and clear only when a new header starts.
   always_ff @(posedge tck_i or posedge rst_i) begin
      if (rst_i) begin
         hdr_q     <= '0;
         aux_cnt_q <= '0;
         bit_cnt_q <= '0;
         frames_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else if (!en_i) begin
         hdr_q     <= '0;
         aux_cnt_q <= '0;
         bit_cnt_q <= '0;
         frames_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               done_q    <= 1'b0;
               err_q     <= 1'b0;
               aux_cnt_q <= '0;
            end
            ST_HDR: begin
               hdr_q     <= hdr_next;
               aux_cnt_q <= aux_cnt_q + AUX_W'(1);
               if (hdr_last) begin
                  aux_cnt_q <= '0;
                  frames_q  <= hdr_next[FC_LSB +: FC_W];
                  if (hdr_bad) begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               bit_cnt_q <= bit_cnt_q + BIT_W'(1);
`ifndef PMU_CRC_EN
               if (bit_last) begin
                  frames_q <= frames_q - FC_W'(1);
                  if (last_frame) begin
                     done_q <= 1'b1;
                  end
               end
`endif
            end
            ST_CRC: begin
               aux_cnt_q <= crc_last ? '0 : aux_cnt_q + AUX_W'(1);
            end
            ST_CHECK: begin
               if (crc_rem != '0) begin
                  err_q <= 1'b1;
               end else begin
                  frames_q <= frames_q - FC_W'(1);
                  if (last_frame) begin
                     done_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Enable is sampled on the falling edge so the AND gate only opens while tck_i is low.
   assign clk_en_d = en_i && (state_q == ST_DATA) && (!last_frame || bit_in_len);

   always_ff @(negedge tck_i or posedge rst_i) begin
      if (rst_i) begin
         clk_en_q <= 1'b0;
      end else begin
         clk_en_q <= clk_en_d;
      end
   end

   always_comb begin
      busy_o      = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
      data_o      = data_i;
      done_o      = done_q;
      err_o       = err_q;
      progclk_o   = '0;
      data_ccff_o = 1'b0;
      for (int unsigned i = 0; i < N_CHAINS; i++) begin
         if (32'(chain_sel) == i) begin
            progclk_o[i] = tck_i & clk_en_q;
            if (state_q != ST_IDLE) begin
               data_ccff_o = data_ccff_i[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_pmu_frame_ctrl.sv
// Directed bench for pmu_frame_ctrl; CRC-specific scenarios follow PMU_CRC_EN.
module tb_pmu_frame_ctrl;

   localparam int unsigned N_CHAINS = 4;
   localparam int unsigned FRAME_W  = 64;
   localparam int unsigned CRC_W    = 8;
   localparam logic [7:0]  CRC_POLY = 8'h2F;

   logic                tck_i = 1'b0;
   logic                rst_i;
   logic                en_i;
   logic                data_i;
   logic [N_CHAINS-1:0] data_ccff_i;
   logic                data_o;
   logic [N_CHAINS-1:0] progclk_o;
   logic                data_ccff_o;
   logic                busy_o;
   logic                done_o;
   logic                err_o;

   always #5 tck_i = ~tck_i;

   pmu_frame_ctrl #(
      .N_CHAINS (N_CHAINS),
      .FRAME_W  (FRAME_W),
      .CRC_W    (CRC_W),
      .CRC_POLY (CRC_POLY)
   ) dut (
      .tck_i       (tck_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .data_i      (data_i),
      .data_ccff_i (data_ccff_i),
      .data_o      (data_o),
      .progclk_o   (progclk_o),
      .data_ccff_o (data_ccff_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse bookkeeping: gated clock is high just after a posedge of tck_i when enabled.
   int pulses [N_CHAINS] = '{default: 0};
   int run0     = 0;
   int max_run0 = 0;
   int both_hi  = 0;
   int fwd_bad  = 0;

   always @(posedge tck_i) begin
      #1;
      for (int i = 0; i < N_CHAINS; i++) begin
         if (progclk_o[i]) pulses[i]++;
      end
      if (progclk_o[0]) begin
         run0++;
         if (run0 > max_run0) max_run0 = run0;
      end else begin
         run0 = 0;
      end
   end

   always @(negedge tck_i) begin
      if (done_o && err_o) both_hi++;
      if (data_o !== data_i) fwd_bad++;
   end

   function automatic logic [7:0] crc_of(input logic [63:0] d);
      logic [7:0] rem;
      logic       fb;
      rem = '0;
      for (int i = 0; i < 64; i++) begin
         fb  = rem[7] ^ d[i];
         rem = {rem[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
      return rem;
   endfunction

   task automatic send_bit(input logic b);
      data_i = b;
      @(negedge tck_i);
   endtask

   task automatic send_header(input logic [31:0] fc, input logic [15:0] ll, input logic [7:0] cs);
      logic [63:0] h;
      h = {8'hA5, cs, ll, fc};
      for (int i = 0; i < 64; i++) send_bit(h[i]);
   endtask

   task automatic run_frame(input logic [63:0] d, input logic [7:0] flip);
      logic [7:0] c;
      for (int i = 0; i < 64; i++) send_bit(d[i]);
      c = crc_of(d) ^ flip;
`ifdef PMU_CRC_EN
      for (int i = 7; i >= 0; i--) send_bit(c[i]);
      send_bit(1'b0);
`endif
   endtask

   task automatic start_session();
      en_i = 1'b1;
      @(negedge tck_i);
   endtask

   task automatic end_session();
      en_i = 1'b0;
      @(negedge tck_i);
   endtask

   localparam logic [63:0] D0 = 64'hA5C3_0F1E_9B7D_2468;
   localparam logic [63:0] D1 = 64'h1357_9BDF_0246_8ACE;
   localparam logic [63:0] D2 = 64'hFFFF_0000_F0F0_3C3C;
   localparam logic [63:0] D3 = 64'h8000_0000_0000_0001;

   int base [N_CHAINS];
   int other;

   initial begin
      rst_i       = 1'b1;
      en_i        = 1'b0;
      data_i      = 1'b0;
      data_ccff_i = '1;
      #12;
      check_val("rst_busy", busy_o, 0);
      check_val("rst_done", done_o, 0);
      check_val("rst_err", err_o, 0);
      check_val("rst_progclk", progclk_o, 0);
      check_val("rst_ccff", data_ccff_o, 0);
      @(negedge tck_i);
      rst_i = 1'b0;
      @(negedge tck_i);
      check_val("idle_no_en", busy_o, 0);

      // Two full frames on chain 1
      base = pulses;
      start_session();
      check_val("hdr_busy", busy_o, 1);
      send_header(32'd2, 16'd64, 8'd1);
      data_ccff_i = 4'b0010;
      #1 check_val("ccff_sel_hi", data_ccff_o, 1);
      data_ccff_i = 4'b1101;
      #1 check_val("ccff_sel_lo", data_ccff_o, 0);
      check_val("data_busy", busy_o, 1);
      run_frame(D0, 8'h00);
      run_frame(D1, 8'h00);
      check_val("a_pulses1", pulses[1] - base[1], 128);
      other = (pulses[0] - base[0]) + (pulses[2] - base[2]) + (pulses[3] - base[3]);
      check_val("a_pulses_other", other, 0);
      check_val("a_done", done_o, 1);
      check_val("a_err", err_o, 0);
      check_val("a_busy", busy_o, 0);
      end_session();
      check_val("a_done_sticky", done_o, 1);
      check_val("a_idle_ccff", data_ccff_o, 0);

      // Short last frame: 10 of 64 bits clocked
      base = pulses;
      start_session();
      check_val("b_done_clr", done_o, 0);
      send_header(32'd1, 16'd10, 8'd0);
      run_frame(D2, 8'h00);
      check_val("b_pulses0", pulses[0] - base[0], 10);
      check_val("b_done", done_o, 1);
      end_session();

`ifdef PMU_CRC_EN
      // Corrupted CRC on the second frame
      base = pulses;
      start_session();
      send_header(32'd2, 16'd64, 8'd1);
      run_frame(D0, 8'h00);
      check_val("c_mid_err", err_o, 0);
      run_frame(D1, 8'h08);
      check_val("c_err", err_o, 1);
      check_val("c_done", done_o, 0);
      check_val("c_pulses1", pulses[1] - base[1], 128);
      end_session();
`endif

      // Header errors: chain_sel out of range, then frame_count zero
      base = pulses;
      start_session();
      send_header(32'd1, 16'd0, 8'd7);
      check_val("d_sel_err", err_o, 1);
      check_val("d_sel_busy", busy_o, 0);
      check_val("d_sel_done", done_o, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      other = 0;
      for (int i = 0; i < N_CHAINS; i++) other += pulses[i] - base[i];
      check_val("d_sel_pulses", other, 0);
      end_session();
      check_val("d_err_sticky", err_o, 1);
      start_session();
      check_val("d_err_clr", err_o, 0);
      send_header(32'd0, 16'd64, 8'd0);
      check_val("d_fc0_err", err_o, 1);
      end_session();

      // Asynchronous reset in the middle of a frame
      data_ccff_i = 4'b0100;
      start_session();
      send_header(32'd1, 16'd0, 8'd2);
      for (int i = 0; i < 30; i++) send_bit(D3[i]);
      data_i = 1'b1;
      @(posedge tck_i);
      #1 check_val("e_pre_clk", progclk_o, 4'b0100);
      check_val("e_pre_ccff", data_ccff_o, 1);
      #1 rst_i = 1'b1;
      #1;
      check_val("e_rst_clk", progclk_o, 0);
      check_val("e_rst_busy", busy_o, 0);
      check_val("e_rst_ccff", data_ccff_o, 0);
      check_val("e_rst_flags", {done_o, err_o}, 0);
      en_i = 1'b0;
      @(negedge tck_i);
      rst_i = 1'b0;
      @(negedge tck_i);
      base = pulses;
      start_session();
      send_header(32'd1, 16'd0, 8'd3);
      run_frame(D3, 8'h00);
      check_val("e_fresh_pulses3", pulses[3] - base[3], 64);
      check_val("e_fresh_done", done_o, 1);
      check_val("e_fresh_err", err_o, 0);
      end_session();

`ifndef PMU_CRC_EN
      // Back-to-back frames without CRC
      base = pulses;
      start_session();
      send_header(32'd3, 16'd64, 8'd0);
      run_frame(D0, 8'h00);
      run_frame(D1, 8'h00);
      check_val("f_mid_done", done_o, 0);
      run_frame(D2, 8'h00);
      check_val("f_pulses0", pulses[0] - base[0], 192);
      check_val("f_run", max_run0, 192);
      check_val("f_done", done_o, 1);
      check_val("f_err", err_o, 0);
      end_session();
`endif

      check_val("flags_exclusive", both_hi, 0);
      check_val("data_forward", fwd_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
